// File: rtl/comp_mul_round_sat.sv
// Output conditioning after the complex multiply stage: convergent rounding, saturation to OUT_W
// bits, valid/ready handshake and a sticky saturation-event counter. 2-cycle latency, 1 sample/cycle.
module comp_mul_round_sat #(
  parameter int IN_W       = 48,
  parameter int FRAC_SHIFT = 14,
  parameter int OUT_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  input  logic signed [IN_W-1:0]  RE_IN,
  input  logic signed [IN_W-1:0]  IM_IN,
  input  logic                    VALID_IN,
  output logic                    READY_OUT,
  output logic signed [OUT_W-1:0] RE_OUT,
  output logic signed [OUT_W-1:0] IM_OUT,
  output logic                    VALID_OUT,
  input  logic                    READY_IN,
  output logic                    SAT_OUT,
  input  logic                    CLR_CNT_IN,
  output logic [CNT_W-1:0]        SAT_CNT_OUT
);

  // One guard bit above the shifted word so the rounding increment never wraps.
  localparam int R_W = IN_W - FRAC_SHIFT + 1;

  localparam logic [FRAC_SHIFT-1:0] C_HALF = FRAC_SHIFT'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [R_W-1:0] C_MAX  = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] C_MIN  = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    r_s1_vld;
  logic signed [R_W-1:0]   r_s1_re;
  logic signed [R_W-1:0]   r_s1_im;
  logic                    r_s2_vld;
  logic signed [OUT_W-1:0] r_re_out;
  logic signed [OUT_W-1:0] r_im_out;
  logic                    r_sat;
  logic [CNT_W-1:0]        r_sat_cnt;

  logic                    w_en;
  logic signed [R_W-1:0]   w_re_rnd;
  logic signed [R_W-1:0]   w_im_rnd;
  logic signed [OUT_W-1:0] w_re_sat;
  logic signed [OUT_W-1:0] w_im_sat;
  logic                    w_re_flag;
  logic                    w_im_flag;

  function automatic logic signed [R_W-1:0] round_conv(input logic signed [IN_W-1:0] x);
    logic signed [R_W-1:0]  q;
    logic [FRAC_SHIFT-1:0]  f;
    logic                   up;
    q  = {x[IN_W-1], x[IN_W-1:FRAC_SHIFT]};
    f  = x[FRAC_SHIFT-1:0];
    up = (f > C_HALF) || ((f == C_HALF) && q[0]);
    return q + {{(R_W-1){1'b0}}, up};
  endfunction

  // Returns {flag, value}.
  function automatic logic [OUT_W:0] sat_conv(input logic signed [R_W-1:0] r);
    if (r > C_MAX)      return {1'b1, C_MAX[OUT_W-1:0]};
    else if (r < C_MIN) return {1'b1, C_MIN[OUT_W-1:0]};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  assign w_en      = !r_s2_vld || READY_IN;
  assign READY_OUT = w_en;

  always_comb begin
    w_re_rnd               = round_conv(RE_IN);
    w_im_rnd               = round_conv(IM_IN);
    {w_re_flag, w_re_sat}  = sat_conv(r_s1_re);
    {w_im_flag, w_im_sat}  = sat_conv(r_s1_im);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_s1_vld  <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s2_vld  <= 1'b0;
      r_re_out  <= '0;
      r_im_out  <= '0;
      r_sat     <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (w_en) begin
        r_s1_vld <= VALID_IN;
        r_s1_re  <= w_re_rnd;
        r_s1_im  <= w_im_rnd;
        r_s2_vld <= r_s1_vld;
        r_re_out <= w_re_sat;
        r_im_out <= w_im_sat;
        r_sat    <= r_s1_vld && (w_re_flag || w_im_flag);
      end
      // Clear wins over a same-cycle saturating load; the count sticks at all-ones.
      if (CLR_CNT_IN)
        r_sat_cnt <= '0;
      else if (w_en && r_s1_vld && (w_re_flag || w_im_flag) && (r_sat_cnt != '1))
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign RE_OUT      = r_re_out;
  assign IM_OUT      = r_im_out;
  assign VALID_OUT   = r_s2_vld;
  assign SAT_OUT     = r_sat;
  assign SAT_CNT_OUT = r_sat_cnt;

endmodule

// File: tb/tb_comp_mul_round_sat.sv
// Bench for comp_mul_round_sat: arithmetic reference model plus scoreboard, directed and random stimulus.
module tb_comp_mul_round_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vin, rin, clr;
  logic signed [47:0] re_in, im_in;
  logic rdy_out, vout, sat;
  logic signed [15:0] re_out, im_out;
  logic [15:0] cnt;
  logic rdy_out4, vout4, sat4;
  logic signed [15:0] re4, im4;
  logic [3:0] cnt4;

  comp_mul_round_sat dut (
    .CLK_IN(clk), .RST_IN(rst), .RE_IN(re_in), .IM_IN(im_in), .VALID_IN(vin),
    .READY_OUT(rdy_out), .RE_OUT(re_out), .IM_OUT(im_out), .VALID_OUT(vout),
    .READY_IN(rin), .SAT_OUT(sat), .CLR_CNT_IN(clr), .SAT_CNT_OUT(cnt));

  comp_mul_round_sat #(.CNT_W(4)) dut4 (
    .CLK_IN(clk), .RST_IN(rst), .RE_IN(re_in), .IM_IN(im_in), .VALID_IN(vin),
    .READY_OUT(rdy_out4), .RE_OUT(re4), .IM_OUT(im4), .VALID_OUT(vout4),
    .READY_IN(rin), .SAT_OUT(sat4), .CLR_CNT_IN(clr), .SAT_CNT_OUT(cnt4));

  int n_chk = 0, n_pass = 0, cyc = 0, rmode = 0, pat = 0;
  bit strict = 0, armed = 0, shown = 0, rst_last = 0, clr_last = 0;
  int mcnt = 0, mcnt4 = 0;

  typedef struct { logic signed [15:0] re; logic signed [15:0] im; bit sat; int stamp; } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: floor-shift, round half to even on the remainder, clamp to 16-bit signed.
  function automatic void ref_comp(input logic signed [47:0] x, output logic signed [15:0] y,
                                   output bit s);
    longint xl, qq, f;
    xl = x;
    qq = xl >>> 14;
    f  = xl - qq * 16384;
    if (f > 8192 || (f == 8192 && (qq & 1) != 0)) qq = qq + 1;
    s = 0;
    if (qq > 32767) begin qq = 32767; s = 1; end
    else if (qq < -32768) begin qq = -32768; s = 1; end
    y = qq[15:0];
  endfunction

  function automatic logic signed [47:0] rnd_val();
    logic [63:0] t;
    longint v;
    t = {$urandom, $urandom};
    case ($urandom % 4)
      0: v = longint'($signed(t[47:0]));
      1: v = (longint'($urandom_range(0, 80000)) - 40000) * 16384 + longint'($urandom_range(0, 16383));
      2: v = (longint'($urandom_range(0, 70000)) - 35000) * 16384 + 8192;
      default: v = longint'($urandom_range(0, 2000000)) - 1000000;
    endcase
    return v[47:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // READY_IN driver: 0 held high, 1 pattern 1,0,0,..., 2 random, 3 held low.
  initial begin
    rin = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: rin = 1'b1;
        1: begin rin = (pat % 3 == 0); pat++; end
        2: rin = 1'($urandom % 2);
        default: rin = 1'b0;
      endcase
    end
  end

  // Scoreboard: outputs of the previous edge checked here, then this cycle's handshakes recorded.
  always @(negedge clk) begin
    exp_t e;
    bit s1, s2;
    if (rst_last) begin
      q.delete(); shown = 0; mcnt = 0; mcnt4 = 0; armed = 1;
    end else if (armed) begin
      if (vout && q.size() > 0 && !shown) begin
        shown = 1;
        if (strict) chk("latency", cyc - q[0].stamp, 2);
        if (q[0].sat) begin
          if (mcnt < 65535) mcnt++;
          if (mcnt4 < 15) mcnt4++;
        end
      end
      if (clr_last) begin mcnt = 0; mcnt4 = 0; end
    end
    if (armed) begin
      chk("ready_out", rdy_out, !vout || rin);
      if (vout) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("re_out", re_out, q[0].re);
          chk("im_out", im_out, q[0].im);
          chk("sat_out", sat, q[0].sat);
        end
      end else if (q.size() > 0) chk("overdue_sample", (cyc - q[0].stamp >= 2), 0);
      if (vout4) begin
        if (q.size() == 0) chk("spurious_valid4", 1, 0);
        else begin
          chk("re_out4", re4, q[0].re);
          chk("im_out4", im4, q[0].im);
          chk("sat_out4", sat4, q[0].sat);
        end
      end
      chk("sat_cnt", cnt, mcnt);
      chk("sat_cnt4", cnt4, mcnt4);
      if (!rst && vout && rin && q.size() > 0) begin void'(q.pop_front()); shown = 0; end
      if (!rst && vin && rdy_out) begin
        ref_comp(re_in, e.re, s1);
        ref_comp(im_in, e.im, s2);
        e.sat = s1 | s2;
        e.stamp = cyc;
        q.push_back(e);
      end
    end
    rst_last = rst;
    clr_last = clr;
  end

  task automatic send(input logic signed [47:0] r, input logic signed [47:0] i);
    int w;
    bit acc;
    w = 0;
    re_in = r; im_in = i; vin = 1'b1;
    do begin
      @(negedge clk); acc = rdy_out && !rst;
      @(posedge clk); #1; w++;
    end while (!acc && w < 200);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    vin = 1'b0;
    while (q.size() > 0 && w < 500) begin step(); w++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    logic signed [15:0] y;
    bit s;
    rst = 1; vin = 0; clr = 0; re_in = '0; im_in = '0;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    @(negedge clk);
    chk("rst_valid", vout, 0); chk("rst_re", re_out, 0); chk("rst_im", im_out, 0);
    chk("rst_sat", sat, 0); chk("rst_cnt", cnt, 0); chk("rst_ready", rdy_out, 1);
    step();

    ref_comp(57344, y, s);  chk("model_tie_3p5", y, 4);
    ref_comp(40960, y, s);  chk("model_tie_2p5", y, 2);
    ref_comp(-40960, y, s); chk("model_tie_m2p5", y, -2);
    ref_comp(-57344, y, s); chk("model_tie_m3p5", y, -4);
    ref_comp(24576, y, s);  chk("model_tie_1p5", y, 2);
    ref_comp(16384*5+8193, y, s); chk("model_above_half", y, 6);
    ref_comp(16384*5+8191, y, s); chk("model_below_half", y, 5);
    ref_comp(-1, y, s);     chk("model_minus_one", y, 0);
    ref_comp(40000*16384, y, s);  chk("model_sat_pos", y, 32767); chk("model_sat_pos_flag", s, 1);
    ref_comp(-40000*16384, y, s); chk("model_sat_neg", y, -32768);
    ref_comp(32767*16384+8192, y, s); chk("model_tie_to_overflow", y, 32767); chk("model_tie_flag", s, 1);

    // Ties and non-ties, back to back with READY_IN high.
    strict = 1;
    send(57344, 24576); send(40960, 24576); send(-40960, 24576); send(-57344, 24576);
    send(16384*5+8193, 0); send(16384*5+8191, 0); send(-1, 0);
    drain();

    // Saturation on both rails, then a tie that rounds past full scale.
    send(40000*16384, -40000*16384);
    send(32767*16384+8192, 0);
    drain();
    chk("cnt_after_sat", cnt, 2);

    // Backpressure with the 1,0,0 READY_IN pattern.
    strict = 0; rmode = 1;
    for (int i = 0; i < 8; i++) send(48'(i * 16384), 48'(-i * 16384));
    drain();
    rmode = 0; step(); step();

    // Counter stick at all-ones on the narrow counter, then clear racing a saturating load.
    strict = 1;
    for (int i = 0; i < 20; i++) send(40000*16384, 0);
    drain();
    chk("cnt4_stuck", cnt4, 15);
    chk("cnt_22", cnt, 22);
    send(-40000*16384, 0);
    vin = 0; clr = 1;
    step();
    clr = 0;
    @(negedge clk);
    chk("clr_race_valid", vout, 1); chk("clr_race_sat", sat, 1);
    chk("clr_race_cnt", cnt, 0); chk("clr_race_cnt4", cnt4, 0);
    step();
    drain();

    // Reset with both stages full and READY_IN low.
    strict = 0; rmode = 3; step(); step();
    send(40000*16384, 0);
    send(3*16384, 0);
    vin = 0;
    @(negedge clk);
    chk("full_ready_low", rdy_out, 0); chk("full_valid", vout, 1); chk("full_cnt", cnt, 1);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("mid_rst_valid", vout, 0); chk("mid_rst_re", re_out, 0); chk("mid_rst_im", im_out, 0);
    chk("mid_rst_cnt", cnt, 0); chk("mid_rst_ready", rdy_out, 1);
    rmode = 0; step(); step();
    strict = 1;
    send(7*16384, -7*16384);
    drain();

    // Random traffic with random backpressure and occasional clears.
    strict = 0; rmode = 2;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom % 20 == 0);
      if ($urandom % 4 == 0) begin vin = 0; step(); end
      send(rnd_val(), rnd_val());
    end
    clr = 0;
    drain();
    rmode = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
